fp_add_sub_pipe: RTL and testbench
==================================

Name: fp_add_sub_pipe

Overview:
- Parametrised, pipelined IEEE-754 floating-point adder/subtractor.
- Successor to the single-precision combinational-plus-output-register adder.
- Generic exponent/mantissa widths, 3-stage pipeline with valid/ready handshake, full special-case handling, round-to-nearest-even and exception flags.
- Sits between operand-issue logic and result writeback in the FP datapath.

Parameters:
- EXP_BITS, 8, exponent field width (≥4)
- MANT_BITS, 23, stored fraction width (≥4)
- WIDTH, 1+EXP_BITS+MANT_BITS, operand/result width (derived; not overridden)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset (reset==0 clears block)
- in_valid  in  1  operands present
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- operation_select  in  1  0 = a+b, 1 = a-b
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  IEEE result
- flags  out  4  {invalid, overflow, underflow, inexact}, aligned with result

Behaviour:
- Reset (reset==0, async): all stage valid bits = 0, out_valid = 0, result = 0, flags = 0. In-flight operations are discarded. in_ready = 1 once reset is deasserted.
- Handshake:
  - Transfer-in when in_valid && in_ready; transfer-out when out_valid && out_ready.
  - advance = !out_valid || out_ready; in_ready = advance.
  - All stages shift together when advance = 1; all hold when advance = 0.
  - Bubbles are not collapsed.
  - result/flags stable while out_valid && !out_ready.
- Latency: exactly 3 cycles from accept to out_valid when unstalled. Throughput 1/cycle. Strict in-order.
- Stage 1 (unpack/align):
  - Effective sign_b = b sign XOR operation_select.
  - Classify each operand: zero, subnormal, normal, inf, qNaN, sNaN.
  - Hidden bit = 1 for normal operands.
  - Swap so the larger magnitude (exp, then mantissa) is operand X.
  - Shift smaller mantissa right by exponent difference, extended with guard, round and sticky bits. Shifts ≥ MANT_BITS+3 leave only sticky.
- Stage 2 (add): add or subtract extended mantissas (width MANT_BITS+4 plus carry) according to sign equality. Result sign = sign of X.
- Stage 3 (normalize/round):
  - Carry → shift right 1, exponent+1.
  - Otherwise leading-zero count, left shift, exponent−count.
  - Round to nearest, ties to even, using G/R/S. A rounding carry renormalises.
- Special cases (priority order):
  - Any NaN input → canonical qNaN (sign 0, exponent all-ones, fraction MSB 1, rest 0). invalid = 1 if either input is sNaN.
  - inf + (−inf) effective → canonical qNaN, invalid = 1.
  - Any inf otherwise → that inf, flags 0.
  - Exact zero sum of opposite-sign operands → +0.
  - (−0)+(−0) → −0.
- Overflow: rounded exponent ≥ all-ones → signed inf; overflow = 1, inexact = 1.
- inexact = 1 whenever any G/R/S bit discarded is nonzero.

Optional Feature:
- Macro: FP_ADD_SUB_SUBNORMAL_EN
- Defined:
  - Gradual underflow. Subnormal inputs use hidden bit 0 and exponent 1.
  - Results below the minimum normal are denormalised before rounding and emitted as subnormals.
  - underflow = 1 when the result is tiny (after rounding) and inexact.
- Undefined (flush-to-zero):
  - Subnormal inputs are treated as signed zero.
  - Results with exponent below 1 after normalisation become signed zero, with underflow = 1 and inexact = 1.
  - Saves the denormalising shifter.

Test Plan:
1. a=0x3F800000, b=0x40000000, op=0 → result 0x40400000, flags 0000, out_valid exactly 3 cycles after accept.
2. a=0x3F800000, b=0x3F800000, op=1 → 0x00000000, flags 0000. a=0x80000000, b=0x00000000, op=1 → 0x80000000.
3. a=0x7F800000, b=0x7F800000, op=1 → 0x7FC00000, invalid=1. a=0x7F800001 (sNaN), b=0x3F800000 → 0x7FC00000, invalid=1.
4. a=b=0x7F7FFFFF, op=0 → 0x7F800000, overflow=1, inexact=1.
5. RNE ties:
   - 0x3F800000 + 0x33800000 → 0x3F800000, inexact=1.
   - 0x3F800001 + 0x33800000 → 0x3F800002, inexact=1.
6. Backpressure and subnormals:
   - Issue 4 back-to-back ops with out_ready=0 for 5 cycles → in_ready drops, 4 results later emerge in order, none lost or duplicated. Assert reset mid-stream → out_valid=0 immediately.
   - 0x00800000 − 0x00400000: result 0x00800000 without the macro, 0x00400000 with it.

Source files
------------

// File: rtl/fp_add_sub_pipe.sv
// ---------------------------------------------------------------------------
// fp_add_sub_pipe
//
// Pipelined IEEE-754 adder/subtractor with generic exponent/fraction widths.
// Three register stages (unpack/align, add, normalise/round) share a single
// advance signal, so the whole pipe moves or stalls as one unit and bubbles
// are kept. Rounding is round-to-nearest-even. Special operands (NaN, inf,
// signed zeros) are resolved in stage 1 and carried down the pipe.
//
// Optional feature macro: FP_ADD_SUB_SUBNORMAL_EN
//   defined   : gradual underflow (subnormal inputs and outputs)
//   undefined : flush-to-zero (subnormal inputs read as signed zero, tiny
//               results become signed zero with underflow+inexact)
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   in_valid/ready   operand handshake (in_ready = !out_valid || out_ready)
//   a, b             operands, WIDTH bits
//   operation_select 0 = a+b, 1 = a-b
//   out_valid/ready  result handshake
//   result           IEEE result, WIDTH bits
//   flags            {invalid, overflow, underflow, inexact}
// ---------------------------------------------------------------------------
module fp_add_sub_pipe #(
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23,
    parameter int WIDTH     = 1 + EXP_BITS + MANT_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             operation_select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);
    localparam int E   = EXP_BITS;
    localparam int M   = MANT_BITS;
    localparam int XTW = M + 4;                         // hidden + fraction + G/R/S
    localparam int LZW = $clog2(M + 5);                 // holds a count of 0..XTW
    localparam int XW  = ((E > LZW) ? E : LZW) + 2;     // signed working exponent

    localparam logic [WIDTH-1:0] QNAN    = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
    localparam logic [XW-1:0]    EXP_MAX = XW'((1 << E) - 1);

    // Leading-zero count over the extended mantissa.
    function automatic logic [LZW-1:0] lzc(input logic [XTW-1:0] v);
        logic [LZW-1:0] n;
        logic           found;
        n     = '0;
        found = 1'b0;
        for (int i = XTW - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + LZW'(1);
            end
        end
        return n;
    endfunction

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // ------------------------------------------------------------------
    // Stage 1: unpack, classify, order by magnitude, align
    // ------------------------------------------------------------------
    logic         sign_a, sign_b;
    logic [E-1:0] exp_a, exp_b, eexp_a, eexp_b;
    logic [M-1:0] frac_a, frac_b;
    logic [M:0]   sig_a, sig_b;
    logic         inf_a, inf_b, nan_a, nan_b, snan_a, snan_b, zero_a, zero_b;

    assign sign_a = a[WIDTH-1];
    assign sign_b = b[WIDTH-1] ^ operation_select;
    assign exp_a  = a[WIDTH-2:M];
    assign exp_b  = b[WIDTH-2:M];
    assign frac_a = a[M-1:0];
    assign frac_b = b[M-1:0];

    assign inf_a  = (&exp_a) && (frac_a == '0);
    assign inf_b  = (&exp_b) && (frac_b == '0);
    assign nan_a  = (&exp_a) && (frac_a != '0);
    assign nan_b  = (&exp_b) && (frac_b != '0);
    assign snan_a = nan_a && !frac_a[M-1];
    assign snan_b = nan_b && !frac_b[M-1];

`ifdef FP_ADD_SUB_SUBNORMAL_EN
    // Subnormals: hidden bit 0, exponent read as 1.
    assign zero_a = (exp_a == '0) && (frac_a == '0);
    assign zero_b = (exp_b == '0) && (frac_b == '0);
    assign eexp_a = (exp_a == '0) ? {{(E-1){1'b0}}, 1'b1} : exp_a;
    assign eexp_b = (exp_b == '0) ? {{(E-1){1'b0}}, 1'b1} : exp_b;
    assign sig_a  = {(exp_a != '0), frac_a};
    assign sig_b  = {(exp_b != '0), frac_b};
`else
    // Flush-to-zero: any zero exponent reads as a signed zero.
    assign zero_a = (exp_a == '0);
    assign zero_b = (exp_b == '0);
    assign eexp_a = exp_a;
    assign eexp_b = exp_b;
    assign sig_a  = (exp_a == '0) ? '0 : {1'b1, frac_a};
    assign sig_b  = (exp_b == '0) ? '0 : {1'b1, frac_b};
`endif

    logic             swap, x_sign, y_sign, y_lost, sp, sp_sub;
    logic [E-1:0]     x_exp, y_exp, diff;
    logic [M:0]       x_sig, y_sig;
    logic [XTW-1:0]   y_raw, y_shift, y_ext;
    logic [WIDTH-1:0] sp_res;
    logic [3:0]       sp_flags;

    always_comb begin
        swap    = {eexp_b, sig_b} > {eexp_a, sig_a};
        x_sign  = swap ? sign_b : sign_a;
        y_sign  = swap ? sign_a : sign_b;
        x_exp   = swap ? eexp_b : eexp_a;
        y_exp   = swap ? eexp_a : eexp_b;
        x_sig   = swap ? sig_b  : sig_a;
        y_sig   = swap ? sig_a  : sig_b;
        sp_sub  = x_sign ^ y_sign;
        diff    = x_exp - y_exp;
        // Every bit shifted past the sticky position is OR-ed into sticky,
        // so very large shifts leave only the sticky bit behind.
        y_raw   = {y_sig, 3'b000};
        y_shift = y_raw >> diff;
        y_lost  = |(y_raw & ~({XTW{1'b1}} << diff));
        y_ext   = {y_shift[XTW-1:1], y_shift[0] | y_lost};

        sp       = 1'b1;
        sp_res   = QNAN;
        sp_flags = 4'b0000;
        if (nan_a || nan_b) begin
            sp_flags = {snan_a | snan_b, 3'b000};
        end else if (inf_a && inf_b && (sign_a != sign_b)) begin
            sp_flags = 4'b1000;
        end else if (inf_a) begin
            sp_res = {sign_a, {E{1'b1}}, {M{1'b0}}};
        end else if (inf_b) begin
            sp_res = {sign_b, {E{1'b1}}, {M{1'b0}}};
        end else if (zero_a && zero_b) begin
            // Only (-0)+(-0) keeps a negative sign.
            sp_res = {sign_a & sign_b, {(WIDTH-1){1'b0}}};
        end else begin
            sp = 1'b0;
        end
    end

    logic             s1_valid, s1_special, s1_sign, s1_sub;
    logic [WIDTH-1:0] s1_sp_res;
    logic [3:0]       s1_sp_flags;
    logic [E-1:0]     s1_exp;
    logic [XTW-1:0]   s1_x, s1_y;

    // ------------------------------------------------------------------
    // Stage 2: add/subtract (X is never smaller than Y, so no negatives)
    // ------------------------------------------------------------------
    logic [XTW:0] sum_next;
    assign sum_next = s1_sub ? ({1'b0, s1_x} - {1'b0, s1_y})
                             : ({1'b0, s1_x} + {1'b0, s1_y});

    logic             s2_valid, s2_special, s2_sign;
    logic [WIDTH-1:0] s2_sp_res;
    logic [3:0]       s2_sp_flags;
    logic [E-1:0]     s2_exp;
    logic [XTW:0]     s2_sum;

    // ------------------------------------------------------------------
    // Stage 3: normalise, round, pack
    // ------------------------------------------------------------------
    logic [LZW-1:0]   lz, shamt;
    logic [XW-1:0]    ex_w, exp_n;
    logic [XTW-1:0]   norm;
    logic [E-1:0]     exp_field;
    logic [E+M-1:0]   rounded;
    logic             inexact, round_up, uf;
    logic [WIDTH-1:0] res_next;
    logic [3:0]       flags_next;
`ifdef FP_ADD_SUB_SUBNORMAL_EN
    logic [XW-1:0]    lim;
`endif

    always_comb begin
        lz    = lzc(s2_sum[XTW-1:0]);
        ex_w  = {{(XW-E){1'b0}}, s2_exp};
        shamt = lz;
        norm  = '0;
        exp_n = '0;
`ifdef FP_ADD_SUB_SUBNORMAL_EN
        lim   = '0;
`endif
        if (s2_sum[XTW]) begin
            norm  = {s2_sum[XTW:2], s2_sum[1] | s2_sum[0]};
            exp_n = ex_w + XW'(1);
        end else begin
`ifdef FP_ADD_SUB_SUBNORMAL_EN
            // Stop the left shift at exponent 1; what remains is subnormal.
            if ({{(XW-LZW){1'b0}}, lz} >= ex_w) begin
                lim   = ex_w - XW'(1);
                shamt = lim[LZW-1:0];
            end
`endif
            norm  = s2_sum[XTW-1:0] << shamt;
            exp_n = ex_w - {{(XW-LZW){1'b0}}, shamt};
        end

        exp_field = norm[XTW-1] ? exp_n[E-1:0] : '0;
        inexact   = |norm[2:0];
        round_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
        // Adding into {exponent, fraction} lets a rounding carry bump the
        // exponent (and promote a subnormal to normal) for free.
        rounded   = {exp_field, norm[XTW-2:3]} + {{(E+M-1){1'b0}}, round_up};
`ifdef FP_ADD_SUB_SUBNORMAL_EN
        uf        = (rounded[E+M-1:M] == '0) && inexact;
`else
        uf        = 1'b0;
`endif

        res_next   = {s2_sign, rounded};
        flags_next = {2'b00, uf, inexact};
        if (s2_special) begin
            res_next   = s2_sp_res;
            flags_next = s2_sp_flags;
        end else if (s2_sum == '0) begin
            res_next   = '0;
            flags_next = 4'b0000;
        end else if ($signed(exp_n) >= $signed(EXP_MAX)) begin
            res_next   = {s2_sign, {E{1'b1}}, {M{1'b0}}};
            flags_next = 4'b0101;
`ifndef FP_ADD_SUB_SUBNORMAL_EN
        end else if ($signed(exp_n) < $signed(XW'(1))) begin
            res_next   = {s2_sign, {(WIDTH-1){1'b0}}};
            flags_next = 4'b0011;
`endif
        end else if (rounded[E+M-1:M] == {E{1'b1}}) begin
            res_next   = {s2_sign, {E{1'b1}}, {M{1'b0}}};
            flags_next = 4'b0101;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers: all stages advance together
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid    <= 1'b0;
            s1_special  <= 1'b0;
            s1_sign     <= 1'b0;
            s1_sub      <= 1'b0;
            s1_sp_res   <= '0;
            s1_sp_flags <= '0;
            s1_exp      <= '0;
            s1_x        <= '0;
            s1_y        <= '0;
            s2_valid    <= 1'b0;
            s2_special  <= 1'b0;
            s2_sign     <= 1'b0;
            s2_sp_res   <= '0;
            s2_sp_flags <= '0;
            s2_exp      <= '0;
            s2_sum      <= '0;
            out_valid   <= 1'b0;
            result      <= '0;
            flags       <= '0;
        end else if (advance) begin
            s1_valid    <= in_valid;
            s1_special  <= sp;
            s1_sign     <= x_sign;
            s1_sub      <= sp_sub;
            s1_sp_res   <= sp_res;
            s1_sp_flags <= sp_flags;
            s1_exp      <= x_exp;
            s1_x        <= {x_sig, 3'b000};
            s1_y        <= y_ext;
            s2_valid    <= s1_valid;
            s2_special  <= s1_special;
            s2_sign     <= s1_sign;
            s2_sp_res   <= s1_sp_res;
            s2_sp_flags <= s1_sp_flags;
            s2_exp      <= s1_exp;
            s2_sum      <= sum_next;
            out_valid   <= s2_valid;
            result      <= res_next;
            flags       <= flags_next;
        end
    end

endmodule

// File: tb/tb_fp_add_sub_pipe.sv
module tb_fp_add_sub_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        operation_select;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    fp_add_sub_pipe dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .a                (a),
        .b                (b),
        .operation_select (operation_select),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .result           (result),
        .flags            (flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    int n_applied = 0;
    int n_miss    = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_applied++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

`ifdef FP_ADD_SUB_SUBNORMAL_EN
    localparam logic [31:0] SUBN_RES  = 32'h0040_0000;
    localparam logic [31:0] TINY_RES  = 32'h0000_0001;
    localparam logic [3:0]  TINY_FLG  = 4'b0000;
`else
    localparam logic [31:0] SUBN_RES  = 32'h0080_0000;
    localparam logic [31:0] TINY_RES  = 32'h0000_0000;
    localparam logic [3:0]  TINY_FLG  = 4'b0011;
`endif

    // Back-to-back sequence operands and expected results
    logic [31:0] seq_a   [4];
    logic [31:0] seq_b   [4];
    logic        seq_op  [4];
    logic [31:0] seq_res [4];

    int  sent, got, cyc, extra;
    bit  fire_in, fire_out, saw_stall;

    initial begin
        // flags order: {invalid, overflow, underflow, inexact}
        vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000};
        vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000};
        vecs[2]  = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000};
        vecs[3]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000};
        vecs[4]  = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000};
        vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101};
        vecs[6]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
        vecs[7]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001};
        vecs[8]  = '{32'h00800000, 32'h00400000, 1'b1, SUBN_RES,     4'b0000};
        vecs[9]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000};
        vecs[10] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000};
        vecs[11] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000};
        vecs[12] = '{32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 4'b0000};
        vecs[13] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000};
        vecs[14] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
        vecs[15] = '{32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 4'b0000};
        vecs[16] = '{32'h00800001, 32'h00800000, 1'b1, TINY_RES,     TINY_FLG};
        vecs[17] = '{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 4'b0101};
        vecs[18] = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001};
        vecs[19] = '{32'h7F800000, 32'hBF800000, 1'b0, 32'h7F800000, 4'b0000};

        seq_a[0] = 32'h3F800000; seq_b[0] = 32'h40000000; seq_op[0] = 1'b0; seq_res[0] = 32'h40400000;
        seq_a[1] = 32'h40000000; seq_b[1] = 32'h40000000; seq_op[1] = 1'b0; seq_res[1] = 32'h40800000;
        seq_a[2] = 32'h40400000; seq_b[2] = 32'h3F800000; seq_op[2] = 1'b1; seq_res[2] = 32'h40000000;
        seq_a[3] = 32'h3F800000; seq_b[3] = 32'h40400000; seq_op[3] = 1'b1; seq_res[3] = 32'hC0000000;

        reset            = 1'b0;
        in_valid         = 1'b0;
        a                = '0;
        b                = '0;
        operation_select = 1'b0;
        out_ready        = 1'b1;

        // Reset state
        #12;
        check32("reset out_valid", {31'b0, out_valid}, 32'd0);
        check32("reset result", result, 32'h0);
        check32("reset flags", {28'b0, flags}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check32("in_ready after reset", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Table-driven single operations
        for (int i = 0; i < NV; i++) begin
            int lat;
            bit seen;
            a                = vecs[i].a;
            b                = vecs[i].b;
            operation_select = vecs[i].op;
            in_valid         = 1'b1;
            out_ready        = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat  = 1;
            seen = 1'b0;
            while (!seen && lat < 10) begin
                if (out_valid) seen = 1'b1;
                else begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
            end
            if (!seen) begin
                n_applied++;
                n_miss++;
                $display("FAIL vec%0d timeout: no out_valid after %0d cycles, required 3", i, lat);
            end else begin
                check32($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
                check32($sformatf("vec%0d result", i), result, vecs[i].res);
                check32($sformatf("vec%0d flags", i), {28'b0, flags}, {28'b0, vecs[i].flg});
                $display("vec %0d: a=%h %s b=%h -> result=%h flags=%b", i, vecs[i].a,
                         vecs[i].op ? "-" : "+", vecs[i].b, result, flags);
            end
            @(posedge clk);
            #1;
        end

        // Back-to-back issue with the consumer stalled for 5 cycles
        sent      = 0;
        got       = 0;
        cyc       = 0;
        saw_stall = 1'b0;
        while (got < 4 && cyc < 60) begin
            in_valid = (sent < 4);
            if (sent < 4) begin
                a                = seq_a[sent];
                b                = seq_b[sent];
                operation_select = seq_op[sent];
            end
            out_ready = (cyc >= 5);
            #1;
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (cyc == 4) check32("in_ready while stalled", {31'b0, in_ready}, 32'd0);
            if (out_valid && !out_ready) begin
                saw_stall = 1'b1;
                check32($sformatf("stalled result cyc%0d", cyc), result, seq_res[got]);
            end
            if (fire_out) begin
                check32($sformatf("stream result %0d", got), result, seq_res[got]);
                $display("stream %0d: result=%h flags=%b", got, result, flags);
                got++;
            end
            @(posedge clk);
            #1;
            if (fire_in) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        check32("stream results delivered", 32'(got), 32'd4);
        check32("stream stall observed", {31'b0, saw_stall}, 32'd1);
        extra = 0;
        repeat (5) begin
            #1;
            if (out_valid) extra++;
            @(posedge clk);
            #1;
        end
        check32("stream duplicates", 32'(extra), 32'd0);

        // Reset in the middle of a stalled stream
        out_ready        = 1'b0;
        in_valid         = 1'b1;
        a                = seq_a[1];
        b                = seq_b[1];
        operation_select = seq_op[1];
        repeat (3) @(posedge clk);
        #1;
        check32("pre-reset out_valid", {31'b0, out_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check32("mid-reset out_valid", {31'b0, out_valid}, 32'd0);
        check32("mid-reset result", result, 32'h0);
        check32("mid-reset flags", {28'b0, flags}, 32'h0);
        in_valid = 1'b0;
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        extra     = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid) extra++;
        end
        check32("post-reset discarded", 32'(extra), 32'd0);
        $display("reset mid-stream: out_valid=%b in_ready=%b", out_valid, in_ready);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
